uart_rx: RTL

// - UART receiver, 8N1 by default; paired with baud_rate_gen, consuming its 16x oversample tick (rx_en_o).
// - Synchronises the async serial line, validates the start bit at mid-bit and samples data/stop bits at bit centres.
// - Delivers each byte on a valid/ready output; flags framing and overrun errors.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver (8N1 by default) driven by a 16x oversample tick.
//
// The asynchronous serial line is brought into the clk_i domain through a
// two-flop synchroniser. A falling edge in IDLE opens a frame. The start bit
// is confirmed at its centre, and the data bits (LSB first) and stop bit are
// sampled at their centres. A good frame is loaded into a single-entry output
// slot with a valid/ready handshake. A low stop bit produces a one-clock
// framing-error pulse. A good frame that finds the slot occupied produces a
// one-clock overrun pulse and is dropped.
//
// Ports
//   clk_i          system clock, all logic on the rising edge
//   rst_n_i        asynchronous active-low reset
//   rx_en_i        one-clock oversample tick, OVERSAMPLE ticks per bit
//   rx_i           asynchronous serial line, idle high
//   rx_data_o      received data, stable while rx_valid_o is high
//   rx_valid_o     data available, held until accepted
//   rx_ready_i     consumer accepts when rx_valid_o & rx_ready_i
//   frame_err_o    one-clock pulse: stop bit sampled low
//   overrun_err_o  one-clock pulse: good frame dropped, slot still occupied
//   busy_o         high whenever a frame is in progress
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_en_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_err_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [1:0]             sync_r;
  logic                   rxs_s;
  logic                   prev_r;
  logic                   armed_r;
  logic [TW-1:0]          tick_r;
  logic [BW-1:0]          bit_r;
  logic [DATA_BITS-1:0]   shift_r;

  assign rxs_s = sync_r[1];

  // Two-flop synchroniser for the serial line; runs every clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_i};
    end
  end

  // Receive FSM, output slot and error pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r       <= IDLE;
      prev_r        <= 1'b1;
      armed_r       <= 1'b0;
      tick_r        <= '0;
      bit_r         <= '0;
      shift_r       <= '0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;

      // Consumer handshake; a load in the same clock below overrides this.
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end else begin
        rx_valid_o <= rx_valid_o;
      end

      if (rx_en_i) begin
        prev_r <= rxs_s;
        // A start is only accepted once the line has been seen high after
        // reset, so a line already low at release cannot open a frame.
        if (rxs_s) begin
          armed_r <= 1'b1;
        end else begin
          armed_r <= armed_r;
        end

        case (state_r)
          IDLE: begin
            if (armed_r && prev_r && !rxs_s) begin
              state_r <= START;
              tick_r  <= '0;
              busy_o  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end

          START: begin
            if (tick_r == TICK_MID) begin
              tick_r <= '0;
              if (!rxs_s) begin
                state_r <= DATA;
                bit_r   <= '0;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state_r <= IDLE;
                busy_o  <= 1'b0;
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end

          DATA: begin
            if (tick_r == TICK_END) begin
              tick_r  <= '0;
              // LSB arrives first, so shift in at the top.
              shift_r <= {rxs_s, shift_r[DATA_BITS-1:1]};
              if (bit_r == BIT_LAST) begin
                state_r <= STOP;
              end else begin
                bit_r <= bit_r + BW'(1);
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end

          STOP: begin
            if (tick_r == TICK_END) begin
              tick_r  <= '0;
              state_r <= IDLE;
              busy_o  <= 1'b0;
              if (rxs_s) begin
                // Slot is free if empty or being emptied in this same clock.
                if (!rx_valid_o || rx_ready_i) begin
                  rx_data_o  <= shift_r;
                  rx_valid_o <= 1'b1;
                end else begin
                  overrun_err_o <= 1'b1;
                end
              end else begin
                frame_err_o <= 1'b1;
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end

          default: begin
            state_r <= IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
